// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port-per-direction BRAM,
// with an optional zero-fill sweep of the whole memory after reset.
module bram_arbiter #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          ADDRESS_WIDTH  = 11,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic                     a_wen,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_rsp_valid,
  output logic [DATA_WIDTH-1:0]    a_rsp_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic                     b_wen,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_rsp_valid,
  output logic [DATA_WIDTH-1:0]    b_rsp_data,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     mem_wen,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_din
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e                     RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [ADDRESS_WIDTH-1:0]   LAST_ADDR   = {ADDRESS_WIDTH{1'b1}};
  localparam logic [ADDRESS_WIDTH-1:0]   ADDR_ONE    = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
  logic                       last_grant_q, last_grant_d;  // 1'b1 = B was granted last
  logic                       a_rsp_valid_q, a_rsp_valid_d;
  logic                       b_rsp_valid_q, b_rsp_valid_d;
  logic                       grant_a, grant_b;

  // State, sweep counter, round-robin pointer and response flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_STATE;
      clear_cnt_q   <= '0;
      last_grant_q  <= 1'b1;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_cnt_q   <= clear_cnt_d;
      last_grant_q  <= last_grant_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
    end
  end

  // Next state, arbitration and memory port steering
  always_comb begin
    state_d       = state_q;
    clear_cnt_d   = clear_cnt_q;
    last_grant_d  = last_grant_q;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    grant_a       = 1'b0;
    grant_b       = 1'b0;
    mem_wen       = 1'b0;
    mem_waddr     = '0;
    mem_din       = '0;
    mem_raddr     = '0;
    case (state_q)
      ST_CLEAR: begin
        // reset_n gating keeps the write strobe low while reset is held
        mem_wen     = reset_n;
        mem_waddr   = clear_cnt_q;
        clear_cnt_d = clear_cnt_q + ADDR_ONE;
        if (clear_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        grant_a = reset_n && a_valid && (!b_valid || last_grant_q);
        grant_b = reset_n && b_valid && (!a_valid || !last_grant_q);
        if (grant_a) begin
          last_grant_d = 1'b0;
          if (a_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = a_addr;
            mem_din   = a_wdata;
          end else begin
            mem_raddr     = a_addr;
            a_rsp_valid_d = 1'b1;
          end
        end else if (grant_b) begin
          last_grant_d = 1'b1;
          if (b_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = b_addr;
            mem_din   = b_wdata;
          end else begin
            mem_raddr     = b_addr;
            b_rsp_valid_d = 1'b1;
          end
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign busy        = (state_q == ST_CLEAR);
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = a_rsp_valid_q ? mem_dout : '0;
  assign b_rsp_data  = b_rsp_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a BRAM model, a transaction-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_bram_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          a_valid = 1'b0, a_wen = 1'b0, b_valid = 1'b0, b_wen = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy, mem_wen;
  logic [DW-1:0] a_rsp_data, b_rsp_data, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_raddr, mem_waddr;

  int n_checks = 0;
  int n_errors = 0;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .busy(busy), .mem_raddr(mem_raddr), .mem_dout(mem_dout),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din)
  );

  always #5 clock = ~clock;

  // BRAM: registered read, write-first; preloaded with junk so the sweep matters
  logic [DW-1:0] bram [DEPTH] = '{default: 16'hDEAD};
  always @(posedge clock) begin
    if (mem_wen) bram[mem_waddr] <= mem_din;
    mem_dout <= (mem_wen && mem_waddr == mem_raddr) ? mem_din : bram[mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep countdown, who won last, and at most one outstanding read
  int            m_clear_left = DEPTH;
  logic [AW-1:0] m_clear_addr = '0;
  logic          m_last_b = 1'b1;
  logic          m_pend_a = 1'b0, m_pend_b = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] ref_mem [DEPTH] = '{default: 16'h0000};
  logic [1:0]    m_win;

  function automatic logic [1:0] pick(input logic av, input logic bv, input logic lastb);
    if (av && bv) return lastb ? 2'd1 : 2'd2;
    if (av) return 2'd1;
    if (bv) return 2'd2;
    return 2'd0;
  endfunction

  assign m_win = (reset_n && m_clear_left == 0) ? pick(a_valid, b_valid, m_last_b) : 2'd0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_clear_left <= DEPTH;
      m_clear_addr <= '0;
      m_last_b     <= 1'b1;
      m_pend_a     <= 1'b0;
      m_pend_b     <= 1'b0;
      m_pend_data  <= '0;
    end else if (m_clear_left > 0) begin
      ref_mem[m_clear_addr] <= '0;
      m_clear_addr <= m_clear_addr + 4'd1;
      m_clear_left <= m_clear_left - 1;
      m_pend_a     <= 1'b0;
      m_pend_b     <= 1'b0;
    end else begin
      m_pend_a    <= (m_win == 2'd1) && !a_wen;
      m_pend_b    <= (m_win == 2'd2) && !b_wen;
      m_pend_data <= (m_win == 2'd1) ? ref_mem[a_addr] : (m_win == 2'd2) ? ref_mem[b_addr] : 16'h0000;
      if (m_win == 2'd1 && a_wen) ref_mem[a_addr] <= a_wdata;
      if (m_win == 2'd2 && b_wen) ref_mem[b_addr] <= b_wdata;
      if (m_win != 2'd0) m_last_b <= (m_win == 2'd2);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      chk("rst_mem_wen", 32'(mem_wen), 32'd0);
      chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    end else if (m_clear_left > 0) begin
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_ready", 32'({a_ready, b_ready}), 32'd0);
      chk("clr_mem_wen", 32'(mem_wen), 32'd1);
      chk("clr_waddr", 32'(mem_waddr), 32'(m_clear_addr));
      chk("clr_din", 32'(mem_din), 32'd0);
      chk("clr_raddr", 32'(mem_raddr), 32'd0);
      chk("clr_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
    end else begin
      chk("busy", 32'(busy), 32'd0);
      chk("a_ready", 32'(a_ready), 32'(m_win == 2'd1));
      chk("b_ready", 32'(b_ready), 32'(m_win == 2'd2));
      chk("mem_wen", 32'(mem_wen), 32'((m_win == 2'd1 && a_wen) || (m_win == 2'd2 && b_wen)));
      chk("mem_waddr", 32'(mem_waddr),
          (m_win == 2'd1 && a_wen) ? 32'(a_addr) : (m_win == 2'd2 && b_wen) ? 32'(b_addr) : 32'd0);
      chk("mem_din", 32'(mem_din),
          (m_win == 2'd1 && a_wen) ? 32'(a_wdata) : (m_win == 2'd2 && b_wen) ? 32'(b_wdata) : 32'd0);
      chk("mem_raddr", 32'(mem_raddr),
          (m_win == 2'd1 && !a_wen) ? 32'(a_addr) : (m_win == 2'd2 && !b_wen) ? 32'(b_addr) : 32'd0);
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_pend_a));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_pend_b));
      chk("a_rsp_data", 32'(a_rsp_data), m_pend_a ? 32'(m_pend_data) : 32'd0);
      chk("b_rsp_data", 32'(b_rsp_data), m_pend_b ? 32'(m_pend_data) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1 right after reset release: 16 sweep cycles, then idle
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_waddr"}, 32'(mem_waddr), 32'(i));
      chk({tag, "_din"}, 32'(mem_din), 32'd0);
      chk({tag, "_wen"}, 32'(mem_wen), 32'd1);
      chk({tag, "_rsp"}, 32'(a_rsp_valid), 32'd0);
    end
    @(negedge clock);
    chk({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_busy_lit", 32'(busy), 32'd1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    sweep_check("init");
    step();

    // Tie on both requesters: A wins first, then strict alternation
    a_valid = 1'b1; a_wen = 1'b0; a_addr = 4'd0;
    b_valid = 1'b1; b_wen = 1'b0; b_addr = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rr_a", 32'(a_ready), 32'(k % 2 == 0));
      chk("rr_b", 32'(b_ready), 32'(k % 2 == 1));
      chk("rr_excl", 32'(a_ready & b_ready), 32'd0);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // Every address reads back zero after the sweep, back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      a_valid = 1'b1; a_wen = 1'b0; a_addr = 4'(i);
      @(negedge clock);
      if (i > 0) begin
        chk("zero_rd_valid", 32'(a_rsp_valid), 32'd1);
        chk("zero_rd_data", 32'(a_rsp_data), 32'd0);
      end
      step();
    end
    a_valid = 1'b0;
    @(negedge clock);
    chk("zero_rd_last", 32'(a_rsp_data), 32'd0);
    step();

    // A writes, B reads the same word next cycle
    a_valid = 1'b1; a_wen = 1'b1; a_addr = 4'd5; a_wdata = 16'hBEEF;
    step();
    a_valid = 1'b0; b_valid = 1'b1; b_wen = 1'b0; b_addr = 4'd5;
    step();
    b_valid = 1'b0;
    @(negedge clock);
    chk("wr_rd_b_valid", 32'(b_rsp_valid), 32'd1);
    chk("wr_rd_b_data", 32'(b_rsp_data), 32'h0000BEEF);
    chk("wr_rd_a_quiet", 32'(a_rsp_valid), 32'd0);
    step();

    // Three writes then three consecutive reads with no bubbles
    for (int i = 1; i <= 3; i++) begin
      a_valid = 1'b1; a_wen = 1'b1; a_addr = 4'(i); a_wdata = 16'(32'h11 * i);
      step();
    end
    for (int i = 1; i <= 3; i++) begin
      a_valid = 1'b1; a_wen = 1'b0; a_addr = 4'(i);
      @(negedge clock);
      if (i > 1) begin
        chk("burst_valid", 32'(a_rsp_valid), 32'd1);
        chk("burst_data", 32'(a_rsp_data), 32'h11 * 32'(i - 1));
      end
      step();
    end
    a_valid = 1'b0;
    @(negedge clock);
    chk("burst_valid3", 32'(a_rsp_valid), 32'd1);
    chk("burst_data3", 32'(a_rsp_data), 32'h00000033);
    step();
    @(negedge clock);
    chk("burst_end", 32'(a_rsp_valid), 32'd0);
    step();

    // Reset mid-sweep at address 7: sweep restarts from 0
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) @(negedge clock);
    chk("abort_at7", 32'(mem_waddr), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_wen", 32'(mem_wen), 32'd0);
    chk("abort_ready", 32'({a_ready, b_ready}), 32'd0);
    step();
    @(posedge clock);
    #1 reset_n = 1'b1;
    sweep_check("restart");
    step();

    // Reset between a read grant and its response: the response is dropped
    a_valid = 1'b1; a_wen = 1'b0; a_addr = 4'd5;
    @(negedge clock);
    chk("drop_grant", 32'(a_ready), 32'd1);
    #2 reset_n = 1'b0;
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("drop_rsp", 32'(a_rsp_valid), 32'd0);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    sweep_check("post_drop");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
